// File: rtl/forth_decode_stage.sv
// Registered, handshaked decode stage for the Forth stack processor.
// It holds one decoded control bundle and can squash wrong-path fetches and stall behind memory reads.
module forth_decode_stage #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FLUSH_N  = 2,
  parameter int unsigned FLUSH_JZ = 1,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       B_op,
  output logic             TWrite,
  output logic             NWrite,
  output logic             RWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Jump,
  output logic             JumpZ,
  output logic             JumpReg,
  output logic [3:0]       AluOp,
  output logic [1:0]       Offset,
  output logic [1:0]       AOffset,
  output logic [WIDTH-1:0] imm,
  output logic             SelectImm,
  output logic             Swap
);

  localparam int unsigned FW = (FLUSH_N > 0) ? $clog2(FLUSH_N + 1) : 1;
  localparam int unsigned MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit JZ_FLUSH = (FLUSH_JZ != 0);
  localparam bit DO_FLUSH = (FLUSH_N > 0);
  localparam bit DO_WAIT  = (MEM_LAT > 1);

  typedef struct packed {
    logic [1:0]       b_op;
    logic             twrite;
    logic             nwrite;
    logic             rwrite;
    logic             memread;
    logic             memwrite;
    logic             jump;
    logic             jumpz;
    logic             jumpreg;
    logic [3:0]       aluop;
    logic [1:0]       offset;
    logic [1:0]       aoffset;
    logic [WIDTH-1:0] imm;
    logic             selectimm;
    logic             swap;
  } ctl_t;

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

  state_t        state_q, state_d;
  ctl_t          ctl_q, ctl_d, dec;
  logic          valid_q, valid_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          rdy_c, accept_c, fire_c, held_ct_c, held_mr_c;

  // Instruction decode, highest-priority format first
  always_comb begin
    dec = '0;
    if (in_instr[WIDTH-1]) begin
      dec.imm       = WIDTH'(in_instr[WIDTH-2:0]);
      dec.selectimm = 1'b1;
      dec.twrite    = 1'b1;
      dec.aluop     = 4'd10;
      dec.offset    = 2'd1;
    end else if (in_instr[WIDTH-1:WIDTH-7] == 7'd0) begin
      dec.b_op    = 2'd2;
      dec.jumpreg = 1'b1;
      dec.aoffset = 2'b11;
      dec.aluop   = 4'd10;
    end else if (in_instr[WIDTH-1:WIDTH-3] == 3'b001) begin
      dec.imm  = WIDTH'(in_instr[WIDTH-4:0]);
      dec.jump = 1'b1;
    end else if (in_instr[WIDTH-1:WIDTH-3] == 3'b010) begin
      dec.imm     = WIDTH'(in_instr[WIDTH-4:0]);
      dec.jump    = 1'b1;
      dec.aoffset = 2'd1;
      dec.aluop   = 4'd10;
      dec.rwrite  = 1'b1;
    end else if (in_instr[WIDTH-1:WIDTH-3] == 3'b011) begin
      dec.imm   = WIDTH'(in_instr[WIDTH-4:0]);
      dec.jumpz = 1'b1;
      dec.aluop = 4'd10;
      dec.swap  = 1'b1;
    end else begin
      dec.aluop   = in_instr[12:9];
      dec.b_op    = in_instr[8:7];
      dec.memread = (in_instr[8:7] == 2'd3);
      case (in_instr[6:5])
        2'd0:    dec.twrite   = 1'b1;
        2'd1:    dec.nwrite   = 1'b1;
        2'd2:    dec.rwrite   = 1'b1;
        default: dec.memwrite = 1'b1;
      endcase
      dec.offset  = in_instr[4:3];
      dec.aoffset = in_instr[2:1];
      dec.swap    = in_instr[0];
    end
  end

  assign held_ct_c = valid_q & (ctl_q.jump | ctl_q.jumpreg | (JZ_FLUSH & ctl_q.jumpz));
  assign held_mr_c = valid_q & ctl_q.memread;
  assign fire_c    = valid_q & out_ready;

  // Ready policy: a held transfer or memory read must leave before anything follows it
  always_comb begin
    rdy_c = 1'b0;
    case (state_q)
      RUN: begin
        if (!valid_q)                     rdy_c = 1'b1;
        else if (held_ct_c || held_mr_c)  rdy_c = 1'b0;
        else                              rdy_c = out_ready;
      end
      FLUSH:   rdy_c = 1'b1;
      default: rdy_c = 1'b0;
    endcase
  end

  assign accept_c = in_valid & rdy_c & ~kill;
  assign in_ready = rdy_c & rst_n & ~kill;

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      RUN: begin
        if (fire_c) valid_d = 1'b0;
        if (fire_c && held_ct_c && DO_FLUSH) begin
          state_d = FLUSH;
          fcnt_d  = FW'(FLUSH_N);
        end else if (fire_c && held_mr_c && DO_WAIT) begin
          state_d = MEMWAIT;
          mcnt_d  = MW'(MEM_LAT - 1);
        end
        if (accept_c) begin
          valid_d = 1'b1;
          ctl_d   = dec;
        end
      end
      FLUSH: begin
        // Only words actually taken from fetch count toward the squash
        if (accept_c) begin
          if (fcnt_q <= FW'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FW'(1);
          end
        end
      end
      MEMWAIT: begin
        if (mcnt_q <= MW'(1)) begin
          state_d = RUN;
          mcnt_d  = '0;
        end else begin
          mcnt_d = mcnt_q - MW'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (kill) begin
      state_d = RUN;
      valid_d = 1'b0;
      ctl_d   = '0;
      fcnt_d  = '0;
      mcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ctl_q   <= '0;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign out_valid = valid_q;
  assign B_op      = ctl_q.b_op;
  assign TWrite    = ctl_q.twrite;
  assign NWrite    = ctl_q.nwrite;
  assign RWrite    = ctl_q.rwrite;
  assign MemRead   = ctl_q.memread;
  assign MemWrite  = ctl_q.memwrite;
  assign Jump      = ctl_q.jump;
  assign JumpZ     = ctl_q.jumpz;
  assign JumpReg   = ctl_q.jumpreg;
  assign AluOp     = ctl_q.aluop;
  assign Offset    = ctl_q.offset;
  assign AOffset   = ctl_q.aoffset;
  assign imm       = ctl_q.imm;
  assign SelectImm = ctl_q.selectimm;
  assign Swap      = ctl_q.swap;

endmodule

// File: tb/tb_forth_decode_stage.sv
// Bench for forth_decode_stage: directed scenarios plus random traffic against a
// cycle-level reference that tracks held bundle, squash budget and wait budget as plain integers.
module tb_forth_decode_stage;
  localparam int unsigned W  = 16;
  localparam int unsigned FN = 2;
  localparam int unsigned ML = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kill = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_instr = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    B_op, Offset, AOffset;
  logic          TWrite, NWrite, RWrite, MemRead, MemWrite, Jump, JumpZ, JumpReg, SelectImm, Swap;
  logic [3:0]    AluOp;
  logic [W-1:0]  imm;
  logic [35:0]   dut_b;

  int nchk = 0;
  int nerr = 0;

  bit          m_valid;
  logic [35:0] m_b;
  int          m_flush;
  int          m_wait;

  forth_decode_stage #(.WIDTH(W), .FLUSH_N(FN), .FLUSH_JZ(1), .MEM_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .B_op(B_op), .TWrite(TWrite), .NWrite(NWrite), .RWrite(RWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Jump(Jump), .JumpZ(JumpZ),
    .JumpReg(JumpReg), .AluOp(AluOp), .Offset(Offset), .AOffset(AOffset),
    .imm(imm), .SelectImm(SelectImm), .Swap(Swap)
  );

  always #5 clk = ~clk;

  assign dut_b = {B_op, TWrite, NWrite, RWrite, MemRead, MemWrite, Jump, JumpZ, JumpReg,
                  AluOp, Offset, AOffset, imm, SelectImm, Swap};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] mk(int bop, int tw, int nw, int rw, int mr, int mw, int j,
                                     int jz, int jr, int alu, int off, int aoff, int immv,
                                     int sel, int sw);
    return {2'(bop), 1'(tw), 1'(nw), 1'(rw), 1'(mr), 1'(mw), 1'(j), 1'(jz), 1'(jr),
            4'(alu), 2'(off), 2'(aoff), 16'(immv), 1'(sel), 1'(sw)};
  endfunction

  // Reference decode from the instruction formats, using shifts and masks on an integer
  function automatic logic [35:0] ref_dec(input logic [15:0] ins);
    int x, top3, dst, bop;
    x    = int'(ins);
    top3 = x >> 13;
    if (x >= 32'h8000)       return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, x & 32'h7FFF, 1, 0);
    if ((x >> 9) == 0)       return mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 3, 0, 0, 0);
    if (top3 == 1)           return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, x & 32'h1FFF, 0, 0);
    if (top3 == 2)           return mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 10, 0, 1, x & 32'h1FFF, 0, 0);
    if (top3 == 3)           return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0, 0, x & 32'h1FFF, 0, 1);
    bop = (x >> 7) & 3;
    dst = (x >> 5) & 3;
    return mk(bop, int'(dst == 0), int'(dst == 1), int'(dst == 2), int'(bop == 3),
              int'(dst == 3), 0, 0, 0, (x >> 9) & 15, (x >> 3) & 3, (x >> 1) & 3, 0, 0, x & 1);
  endfunction

  function automatic bit transfers(input logic [35:0] b);
    return b[28] || b[27] || b[26];
  endfunction

  function automatic bit ref_ready(input logic ordy, input logic k);
    if (k)            return 1'b0;
    if (m_flush > 0)  return 1'b1;
    if (m_wait > 0)   return 1'b0;
    if (!m_valid)     return 1'b1;
    if (transfers(m_b) || m_b[30]) return 1'b0;
    return ordy;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_b     = '0;
    m_flush = 0;
    m_wait  = 0;
  endtask

  // One clock: drive, check at the falling edge, advance the reference at the rising edge
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy, input logic k);
    bit rdy, fire, acc;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    kill      = k;
    @(negedge clk);
    rdy = ref_ready(ordy, k);
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) check("bundle", 64'(dut_b), 64'(m_b));
    @(posedge clk);
    fire = m_valid && ordy;
    acc  = v && rdy;
    if (k) begin
      model_reset();
    end else if (m_flush > 0) begin
      if (acc) m_flush--;
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      if (fire) begin
        m_valid = 1'b0;
        if (transfers(m_b)) m_flush = FN;
        else if (m_b[30])   m_wait  = ML - 1;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_b     = ref_dec(ins);
      end
    end
    #1;
  endtask

  initial begin
    logic [15:0] r;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_bundle", 64'(dut_b), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // imm word
    step(1'b1, 16'h8005, 1'b0, 1'b0);
    check("imm_dec", 64'(dut_b), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 5, 1, 0)));
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // j with two squashed words, held under backpressure first
    step(1'b1, 16'h2010, 1'b0, 1'b0);
    check("j_dec", 64'(dut_b), 64'(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h10, 0, 0)));
    step(1'b1, 16'h8001, 1'b0, 1'b0);
    step(1'b1, 16'h8001, 1'b1, 1'b0);
    step(1'b1, 16'h8001, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h8002, 1'b0, 1'b0);
    step(1'b1, 16'h8003, 1'b0, 1'b0);
    check("after_flush", 64'(dut_b), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 3, 1, 0)));
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // jr followed by its flush
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    check("jr_dec", 64'(dut_b), 64'(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 3, 0, 0, 0)));
    step(1'b1, 16'h0220, 1'b1, 1'b0);
    repeat (3) step(1'b1, 16'h0220, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // memory read stall
    step(1'b1, 16'h0398, 1'b0, 1'b0);
    check("mr_dec", 64'(dut_b), 64'(mk(3, 1, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0)));
    step(1'b1, 16'h8007, 1'b1, 1'b0);
    step(1'b1, 16'h8007, 1'b1, 1'b0);
    step(1'b1, 16'h8007, 1'b1, 1'b0);
    step(1'b1, 16'h8007, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // backpressure, then back-to-back issue
    step(1'b1, 16'h0220, 1'b0, 1'b0);
    repeat (4) step(1'b1, 16'h0240, 1'b0, 1'b0);
    check("bp_hold", 64'(dut_b), 64'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
    step(1'b1, 16'h0240, 1'b1, 1'b0);
    step(1'b1, 16'h0261, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // kill in the middle of a flush
    step(1'b1, 16'h2010, 1'b1, 1'b0);
    step(1'b1, 16'h8001, 1'b1, 1'b0);
    step(1'b1, 16'h8001, 1'b1, 1'b0);
    step(1'b1, 16'h8002, 1'b1, 1'b1);
    step(1'b1, 16'h8009, 1'b0, 1'b0);
    check("kill_next", 64'(dut_b), 64'(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 9, 1, 0)));
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // reset while waiting on memory
    step(1'b1, 16'h0398, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mw_valid", 64'(out_valid), 64'd0);
    check("rst_mw_ready", 64'(in_ready), 64'd0);
    check("rst_mw_bundle", 64'(dut_b), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       r = r & 16'h01FF;
        1:       r = r & 16'h1FFF;
        default: ;
      endcase
      step(1'($urandom_range(0, 9) < 7), r, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/forth_decode_stage.md
# forth_decode_stage

Registered, handshaked instruction-decode stage for the Forth stack processor. It sits between instruction fetch and the stack/ALU datapath and decodes a parametrised-width instruction word into the processor's control bundle. It adds sequencing that a purely combinational decode lacks: a one-deep output register with valid/ready flow control, squashing of wrong-path fetches after control transfers, and issue stalls for multi-cycle memory reads.

## Interface
- WIDTH, 16, instruction and immediate width; legal values are 16 and above.
- FLUSH_N, 2, number of accepted fetch words discarded after a control transfer; 0 disables flushing.
- FLUSH_JZ, 1, when 1, jz also triggers the flush.
- MEM_LAT, 1, memory read latency in cycles; values above 1 insert MEM_LAT-1 stall cycles after a MemRead issues.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- kill  in  1  synchronous flush: empties the output register, clears the counters and returns the FSM to RUN.
- in_valid  in  1  fetch word valid.
- in_instr  in  WIDTH  fetch word.
- in_ready  out  1  this stage accepts in_instr.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  datapath consumes the bundle.
- B_op[1:0], TWrite, NWrite, RWrite, MemRead, MemWrite, Jump, JumpZ, JumpReg, AluOp[3:0], Offset[1:0] (signed), AOffset[1:0] (signed), imm[WIDTH-1:0], SelectImm, Swap  out  registered control bundle.

## Operation
- Decode is evaluated in this priority order (W = WIDTH). All fields not listed are 0.
  - **imm:** instr[W-1]=1 gives imm = zero-extended instr[W-2:0], SelectImm=1, TWrite=1, AluOp=10, Offset=1.
  - **jr:** instr[W-1:W-7]=0 gives B_op=2, JumpReg=1, AOffset=-1, AluOp=10.
  - **j:** instr[W-1:W-3]=001 gives imm = zero-extended instr[W-4:0], Jump=1.
  - **jal:** instr[W-1:W-3]=010 gives j fields plus B_op=0, AOffset=1, AluOp=10, RWrite=1.
  - **jz:** instr[W-1:W-3]=011 gives imm as for j, JumpZ=1, AluOp=10, Swap=1.
  - **ALU (otherwise):** AluOp=instr[12:9], B_op=instr[8:7], MemRead=(instr[8:7]==3). instr[6:5] selects one of TWrite / NWrite / RWrite / MemWrite for values 0..3. Offset=instr[4:3], AOffset=instr[2:1], Swap=instr[0]. Bits W-4..13 are ignored.
- A control transfer is Jump, JumpReg, or (JumpZ when FLUSH_JZ=1).
- FSM states:
  - **RUN:**
    - Output register empty: in_ready=1.
    - Holding an ordinary instruction: in_ready=out_ready.
    - Holding a control transfer or a MemRead: in_ready=0.
    - Exits: when a held control transfer handshakes, go to FLUSH with squash count = FLUSH_N (only if FLUSH_N>0). When a held MemRead handshakes, go to MEMWAIT with wait count = MEM_LAT-1 (only if MEM_LAT>1).
  - **FLUSH:** out_valid=0 and in_ready=1. Each accepted word is dropped and decrements the count. At count 0 the FSM returns to RUN. Cycles with no fetch do not decrement.
  - **MEMWAIT:** in_ready=0 and out_valid=0. The count decrements every cycle and the FSM returns to RUN after it reaches 0.
- kill has priority over every other event in the same cycle. If a handshake coincides with kill, the bundle leaves but no FLUSH or MEMWAIT follows. An input word offered that cycle is not accepted.

## Timing
- Reset: every bundle output is 0, out_valid=0, state is RUN, counters are 0. in_ready is 1 from the first cycle after reset release.
- Latency: a word accepted at edge N has out_valid=1 with its bundle from edge N onward.
- In RUN, back-to-back ordinary instructions sustain one word per cycle.
- The bundle stays stable while out_valid=1 and out_ready=0.
- Reset asserted mid-FLUSH or mid-MEMWAIT aborts immediately to the reset state.
- Counter widths are clog2(FLUSH_N+1) and clog2(MEM_LAT).

## Test plan
- **imm decode:** reset, then feed 16'h8005 -> one cycle later out_valid=1, imm=5, SelectImm=1, TWrite=1, AluOp=10, Offset=1. All other outputs 0.
- **jump with flush:** feed j 16'h2010 then words A, B, C -> bundle Jump=1, imm=16'h0010. A and B are dropped; C is the next bundle. in_ready=0 while j is held and out_ready=0.
- **jr decode:** feed 16'h0000 -> B_op=2, JumpReg=1, AOffset=2'b11, AluOp=10, then a 2-word flush.
- **MemRead stall:** with MEM_LAT=3, feed 16'h0398 then an imm -> AluOp=1, B_op=3, MemRead=1, TWrite=1, Offset=2'b11. After the handshake, in_ready stays 0 for 2 cycles before the imm is accepted.
- **Backpressure:** hold out_ready=0 for 4 cycles with ALU 16'h0220 in the register -> bundle is unchanged (AluOp=1, NWrite=1) and in_ready=0. Releasing out_ready gives one-per-cycle throughput.
- **kill and reset:** assert kill in the middle of a flush after j -> the next word is accepted and issued normally. Assert rst_n=0 mid-MEMWAIT -> all outputs 0 immediately.
